// File: rtl/tone_meter.sv
// Gate-time tone frequency meter: counts rising edges of tone_in over FCLK/GATE_DIV cycles, reports Hz.
// Edge-to-count latency 3 cycles, readdata latency 1; slave never stalls, reads and writes always accepted.
module tone_meter #(
    parameter int unsigned FCLK     = 50_000_000,
    parameter int unsigned GATE_DIV = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tone_in,
    input  logic        address,
    input  logic        read,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic [31:0] writedata
);

    localparam int unsigned   GATE_CYC  = FCLK / GATE_DIV;
    localparam int unsigned   GW        = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYC - 1);
    localparam logic [63:0]   SAT       = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0]   DIV64     = 64'(GATE_DIV);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          enable;

    logic          sync1_q, sync2_q, hist_q;
    logic          edge_now;
    logic [GW-1:0] gate_q, gate_d;
    logic [31:0]   edges_q, edges_d;
    logic          ovf_pend_q, ovf_pend_d;
    logic [31:0]   freq_q, freq_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   gcnt_q, gcnt_d;
    logic [31:0]   readdata_q, readdata_d;

    logic          ctrl_wr, clr, terminal;
    logic [63:0]   total, scaled;
    logic          unused_wdata;

    assign unused_wdata = ^writedata[31:2];

    // tone_in is asynchronous: two flops to resolve metastability, one more to detect the rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= tone_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign edge_now = sync2_q & ~hist_q;
    assign ctrl_wr  = write & address;
    assign clr      = ctrl_wr & writedata[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ctrl_wr) state_d = writedata[0] ? ST_RUN : ST_HOLD;
    end

    always_comb begin
        enable = (state_q == ST_RUN);
    end

    assign terminal = enable && (gate_q == GATE_LAST);
    // An edge arriving on the terminal cycle still belongs to the closing gate
    assign total    = {32'd0, edges_q} + {63'd0, edge_now};
    assign scaled   = total * DIV64;

    always_comb begin
        gate_d     = gate_q;
        edges_d    = edges_q;
        ovf_pend_d = ovf_pend_q;
        freq_d     = freq_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        gcnt_d     = gcnt_q;
        if (!enable) begin
            gate_d     = '0;
            edges_d    = '0;
            ovf_pend_d = 1'b0;
        end else if (terminal) begin
            gate_d     = '0;
            edges_d    = '0;
            ovf_pend_d = 1'b0;
            valid_d    = 1'b1;
            gcnt_d     = gcnt_q + 16'd1;
            if (ovf_pend_q || (scaled > SAT)) begin
                freq_d = '1;
                ovf_d  = 1'b1;
            end else begin
                freq_d = scaled[31:0];
                ovf_d  = 1'b0;
            end
        end else begin
            gate_d = gate_q + GW'(1);
            if (edge_now) begin
                if (edges_q == '1) ovf_pend_d = 1'b1;
                else               edges_d    = edges_q + 32'd1;
            end
        end
        // Clear overrides a coinciding terminal cycle: nothing is latched
        if (clr) begin
            gate_d     = '0;
            edges_d    = '0;
            ovf_pend_d = 1'b0;
            freq_d     = '0;
            valid_d    = 1'b0;
            ovf_d      = 1'b0;
            gcnt_d     = '0;
        end
    end

    always_comb begin
        readdata_d = readdata_q;
        if (read) readdata_d = address ? {gcnt_q, 13'd0, ovf_q, valid_q, enable} : freq_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_q     <= '0;
            edges_q    <= '0;
            ovf_pend_q <= 1'b0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            gcnt_q     <= '0;
            readdata_q <= '0;
        end else begin
            gate_q     <= gate_d;
            edges_q    <= edges_d;
            ovf_pend_q <= ovf_pend_d;
            freq_q     <= freq_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            gcnt_q     <= gcnt_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
